// File: rtl/vga_frame_sync_writer.sv
// Buffers CPU quadrant-colour writes in a small FIFO and replays them to the
// quadrant registers either at the next VSync fall (deferred) or at once (immediate).
//
// state | meaning
// IDLE  | waiting for entries plus a trigger (immediate mode or a VSync fall)
// DRAIN | popping the snapshot of entries taken on entry, one per cycle
module vga_frame_sync_writer #(
  parameter int DEPTH = 4
) (
  input  logic                     iClk_50,
  input  logic                     nRst,
  input  logic                     iWrite,
  input  logic [31:0]              iAddr,
  input  logic [31:0]              iData,
  input  logic                     iVSync,
  output logic                     oWrite,
  output logic [31:0]              oAddr,
  output logic [31:0]              oCR,
  output logic                     oFull,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oDrop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d, remain_q, remain_d;
  logic            mode_q, mode_d;
  logic            s1_q, s2_q, hist_q;
  logic            drop_q, drop_d;
  logic            owr_q, owr_d;
  logic [1:0]      oaddr_q, oaddr_d;
  logic [31:0]     ocr_q, ocr_d;
  logic [33:0]     mem_q [DEPTH];
  logic            fall, pop, push, quad_wr;
  logic            unused_addr;

  assign unused_addr = ^iAddr[31:3];

  // State register
  always_ff @(posedge iClk_50 or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  // Next-state: the drain length is frozen on entry so late pushes wait
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && (mode_q || fall)) begin
          state_d  = DRAIN;
          remain_d = count_q;
        end
      end
      DRAIN: begin
        remain_d = remain_q - CW'(1);
        if (remain_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output
  always_comb begin
    pop = (state_q == DRAIN);
  end

  assign fall = hist_q & ~s2_q;

  always_comb begin
    quad_wr  = iWrite & ~iAddr[2];
    push     = quad_wr & ((count_q != DEPTH_C) | pop);
    drop_d   = quad_wr & ~push;
    mode_d   = (iWrite && iAddr[2]) ? iData[0] : mode_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    owr_d   = pop;
    oaddr_d = pop ? mem_q[rd_ptr_q][33:32] : 2'b00;
    ocr_d   = pop ? mem_q[rd_ptr_q][31:0] : 32'h0;
  end

  always_ff @(posedge iClk_50 or negedge nRst) begin
    if (!nRst) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      hist_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      drop_q   <= 1'b0;
      owr_q    <= 1'b0;
      oaddr_q  <= 2'b00;
      ocr_q    <= 32'h0;
    end else begin
      s1_q     <= iVSync;
      s2_q     <= s1_q;
      hist_q   <= s2_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      drop_q   <= drop_d;
      owr_q    <= owr_d;
      oaddr_q  <= oaddr_d;
      ocr_q    <= ocr_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge iClk_50) begin
    if (push) mem_q[wr_ptr_q] <= {iAddr[1:0], iData};
  end

  assign oWrite = owr_q;
  assign oAddr  = {30'b0, oaddr_q};
  assign oCR    = ocr_q;
  assign oFull  = (count_q == DEPTH_C);
  assign oCount = count_q;
  assign oDrop  = drop_q;

endmodule

// File: tb/tb_vga_frame_sync_writer.sv
// Directed checks of the VGA frame-synchronised quadrant writer: deferred and
// immediate replay, overflow, mid-drain pushes, reset mid-drain, long VSync.
module tb_vga_frame_sync_writer;

  logic        iClk_50;
  logic        nRst;
  logic        iWrite;
  logic [31:0] iAddr;
  logic [31:0] iData;
  logic        iVSync;
  logic        oWrite;
  logic [31:0] oAddr;
  logic [31:0] oCR;
  logic        oFull;
  logic [2:0]  oCount;
  logic        oDrop;

  int n_checks = 0;
  int n_fail   = 0;

  vga_frame_sync_writer #(.DEPTH(4)) dut (
    .iClk_50 (iClk_50),
    .nRst    (nRst),
    .iWrite  (iWrite),
    .iAddr   (iAddr),
    .iData   (iData),
    .iVSync  (iVSync),
    .oWrite  (oWrite),
    .oAddr   (oAddr),
    .oCR     (oCR),
    .oFull   (oFull),
    .oCount  (oCount),
    .oDrop   (oDrop)
  );

  initial iClk_50 = 1'b0;
  always #5 iClk_50 = ~iClk_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk_50);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    iWrite = 1'b1;
    iAddr  = a;
    iData  = d;
    tick();
    iWrite = 1'b0;
    iAddr  = 32'h0;
    iData  = 32'h0;
  endtask

  task automatic idle_check(input int n, input string tag);
    int highs;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (oWrite) highs++;
    end
    check(tag, highs, 0);
  endtask

  task automatic check_out(input string tag, input logic w, input logic [31:0] a, input logic [31:0] c);
    check({tag, "_wr"}, {31'b0, oWrite}, {31'b0, w});
    check({tag, "_addr"}, oAddr, a);
    check({tag, "_cr"}, oCR, c);
  endtask

  initial begin
    nRst   = 1'b1;
    iWrite = 1'b0;
    iAddr  = 32'h0;
    iData  = 32'h0;
    iVSync = 1'b1;
    #2 nRst = 1'b0;
    #1;
    check_out("rst", 1'b0, 32'h0, 32'h0);
    check("rst_drop", {31'b0, oDrop}, 0);
    check("rst_count", {29'b0, oCount}, 0);
    check("rst_full", {31'b0, oFull}, 0);
    tick();
    tick();
    nRst = 1'b1;
    idle_check(3, "rst_release_idle");

    // Deferred: two entries held until VSync falls
    wr(32'h0, 32'hF00);
    wr(32'h3, 32'h0F0);
    check("def_count2", {29'b0, oCount}, 2);
    idle_check(5, "def_hold");
    iVSync = 1'b0;
    tick();
    tick();
    tick();
    check("def_lat_t2", {31'b0, oWrite}, 0);
    tick();
    check_out("def_w0", 1'b1, 32'h0, 32'hF00);
    tick();
    check_out("def_w1", 1'b1, 32'h3, 32'h0F0);
    tick();
    check_out("def_end", 1'b0, 32'h0, 32'h0);
    check("def_count0", {29'b0, oCount}, 0);
    iVSync = 1'b1;
    idle_check(3, "def_vs_high");

    // Overflow: fifth write is dropped, four entries drain
    wr(32'h0, 32'h11);
    wr(32'h1, 32'h22);
    wr(32'h2, 32'h33);
    check("ovf_full3", {31'b0, oFull}, 0);
    wr(32'h3, 32'h44);
    check("ovf_full4", {31'b0, oFull}, 1);
    check("ovf_count4", {29'b0, oCount}, 4);
    check("ovf_nodrop", {31'b0, oDrop}, 0);
    wr(32'h1, 32'h55);
    check("ovf_drop", {31'b0, oDrop}, 1);
    check("ovf_count_keep", {29'b0, oCount}, 4);
    tick();
    check("ovf_drop_pulse", {31'b0, oDrop}, 0);
    iVSync = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check_out("ovf_w0", 1'b1, 32'h0, 32'h11);
    tick();
    check_out("ovf_w1", 1'b1, 32'h1, 32'h22);
    tick();
    check_out("ovf_w2", 1'b1, 32'h2, 32'h33);
    tick();
    check_out("ovf_w3", 1'b1, 32'h3, 32'h44);
    tick();
    check_out("ovf_end", 1'b0, 32'h0, 32'h0);
    check("ovf_count0", {29'b0, oCount}, 0);
    check("ovf_notfull", {31'b0, oFull}, 0);
    iVSync = 1'b1;
    idle_check(3, "ovf_vs_high");

    // Immediate mode
    wr(32'h4, 32'h1);
    check("imm_ctrl_nopush", {29'b0, oCount}, 0);
    wr(32'h2, 32'h00F);
    check("imm_p0_wr", {31'b0, oWrite}, 0);
    check("imm_p0_count", {29'b0, oCount}, 1);
    tick();
    check("imm_p1_wr", {31'b0, oWrite}, 0);
    tick();
    check_out("imm_p2", 1'b1, 32'h2, 32'h00F);
    tick();
    check("imm_done", {31'b0, oWrite}, 0);
    check("imm_count0", {29'b0, oCount}, 0);
    wr(32'h4, 32'h0);

    // Push during a deferred drain waits for the next fall
    wr(32'h0, 32'hA1);
    wr(32'h1, 32'hA2);
    wr(32'h2, 32'hA3);
    iVSync = 1'b0;
    tick();
    tick();
    tick();
    iWrite = 1'b1;
    iAddr  = 32'h1;
    iData  = 32'hABC;
    tick();
    iWrite = 1'b0;
    iAddr  = 32'h0;
    iData  = 32'h0;
    check_out("mid_w0", 1'b1, 32'h0, 32'hA1);
    tick();
    check_out("mid_w1", 1'b1, 32'h1, 32'hA2);
    tick();
    check_out("mid_w2", 1'b1, 32'h2, 32'hA3);
    idle_check(6, "mid_only3");
    check("mid_count1", {29'b0, oCount}, 1);
    iVSync = 1'b1;
    idle_check(3, "mid_vs_high");
    check("mid_count1b", {29'b0, oCount}, 1);
    iVSync = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check_out("mid_next", 1'b1, 32'h1, 32'hABC);
    tick();
    check("mid_count0", {29'b0, oCount}, 0);
    iVSync = 1'b1;
    idle_check(3, "mid_vs_high2");

    // Reset in the second DRAIN cycle
    wr(32'h0, 32'hB1);
    wr(32'h1, 32'hB2);
    wr(32'h2, 32'hB3);
    wr(32'h4, 32'h1);
    tick();
    check("rmd_c1", {31'b0, oWrite}, 0);
    tick();
    check_out("rmd_first", 1'b1, 32'h0, 32'hB1);
    nRst = 1'b0;
    #1;
    check_out("rmd_abort", 1'b0, 32'h0, 32'h0);
    check("rmd_count", {29'b0, oCount}, 0);
    tick();
    tick();
    nRst = 1'b1;
    idle_check(5, "rmd_after");
    wr(32'h1, 32'hCC);
    idle_check(4, "rmd_mode0");
    check("rmd_count1", {29'b0, oCount}, 1);
    iVSync = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check_out("rmd_drain", 1'b1, 32'h1, 32'hCC);
    tick();
    check("rmd_count0", {29'b0, oCount}, 0);
    iVSync = 1'b1;
    idle_check(3, "rmd_vs_high");

    // VSync low for 1000 cycles: a fall with an empty FIFO is not remembered
    iVSync = 1'b0;
    idle_check(10, "long_pre");
    wr(32'h2, 32'hDD);
    idle_check(989, "long_hold");
    check("long_count1", {29'b0, oCount}, 1);
    iVSync = 1'b1;
    idle_check(3, "long_vs_high");
    iVSync = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check_out("long_drain", 1'b1, 32'h2, 32'hDD);
    tick();
    check("long_end_wr", {31'b0, oWrite}, 0);
    check("long_count0", {29'b0, oCount}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_sync_writer.md
VGA_FRAME_SYNC_WRITER -- requirements
Module: vga_frame_sync_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-002 SHALL have port iClk_50 input 1: the single clock; all state on its rising edge.
REQ-003 SHALL have port nRst input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port iWrite input 1: CPU write strobe, one write per high cycle.
REQ-005 SHALL have port iAddr input 32: CPU word address; bit2=0 selects quadrant entry [1:0], bit2=1 selects the control register.
REQ-006 SHALL have port iData input 32: CPU write data.
REQ-007 SHALL have port iVSync input 1: VGA vertical sync, active-low, asynchronous to the write path.
REQ-008 SHALL have port oWrite output 1: quadrant register write strobe.
REQ-009 SHALL have port oAddr output 32: {30'b0, quadrant index}.
REQ-010 SHALL have port oCR output 32: quadrant colour data.
REQ-011 SHALL have port oFull output 1: high when count==DEPTH.
REQ-012 SHALL have port oCount output clog2(DEPTH)+1: FIFO occupancy.
REQ-013 SHALL have port oDrop output 1: one-cycle pulse per rejected write.

Function
REQ-014 SHALL push {iAddr[1:0], iData} when iWrite && !iAddr[2] and (count<DEPTH, or a pop occurs in the same cycle).
REQ-015 SHALL discard a quadrant write when full with no same-cycle pop, and pulse oDrop the next cycle; count unchanged.
REQ-016 SHALL load mode <= iData[0] on iWrite && iAddr[2]; mode 0 = deferred, mode 1 = immediate; control writes never enter the FIFO.
REQ-017 SHALL synchronise iVSync through two flops (s1, s2) plus a history flop; fall = history && !s2.
REQ-018 SHALL implement FSM states IDLE and DRAIN.
REQ-019 IDLE->DRAIN SHALL occur when count>0 and (mode==1, or fall is true); otherwise IDLE holds.
REQ-020 SHALL snapshot n = count on entry to DRAIN; DRAIN pops exactly n entries, one per cycle, in FIFO order, then returns to IDLE.
REQ-021 Entries pushed during DRAIN SHALL NOT be part of the snapshot and SHALL wait for the next trigger.
REQ-022 SHALL register oWrite/oAddr/oCR on each pop; oWrite is high for exactly n consecutive cycles, then low.
REQ-023 Deferred latency: iVSync first sampled low at edge T -> DRAIN at edge T+2 -> first oWrite high after edge T+3.
REQ-024 Immediate latency: push at edge P -> DRAIN at P+1 -> oWrite high after P+2.
REQ-025 A fall with count==0 SHALL be ignored, not remembered; VSync held low SHALL yield one trigger only.
REQ-026 Pointers SHALL wrap modulo DEPTH; count stays within 0..DEPTH.
REQ-027 oAddr[31:2] and the oCR bits of a non-write cycle SHALL be 0.

Reset
REQ-028 nRst low SHALL immediately force: oWrite=0, oAddr=0, oCR=0, oDrop=0, count=0, pointers=0, mode=0, FSM=IDLE.
REQ-029 nRst low SHALL force s1, s2 and history to 1, so no false fall is seen at reset release.
REQ-030 Reset during DRAIN SHALL abort the drain; remaining entries are lost.

Verification
REQ-031 Deferred: writes (0, 0xF00), (3, 0x0F0) with VSync high -> no oWrite; VSync low -> oWrite two cycles: oAddr 0/oCR 0xF00, then oAddr 3/oCR 0x0F0; oCount 0.
REQ-032 Overflow: five writes with VSync high -> oFull after the 4th; 5th pulses oDrop; oCount=4; next fall drains 4 entries only.
REQ-033 Immediate: write addr 4 data 1, then (2, 0x00F) at edge P -> oWrite, oAddr 2, oCR 0x00F after edge P+2.
REQ-034 Push mid-drain: 3 entries drain; push (1, 0xABC) during the drain -> 3 writes only; oCount=1 until the next fall.
REQ-035 Reset mid-drain: nRst low in the 2nd DRAIN cycle -> oWrite 0 at once, oCount 0, mode 0, no oWrite after release.
REQ-036 Long VSync: VSync low 1000 cycles with a push at cycle 10 -> no oWrite until the next fall.
